// File: rtl/systolic_feeder_if.sv
// Operand-in / array-edge bundle between an operand source (master) and the
// systolic feeder (slave).
interface systolic_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int K_WIDTH    = 16
);
  logic                    start;
  logic [K_WIDTH-1:0]      k_len;
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] a_vec;
  logic [N*DATA_WIDTH-1:0] b_vec;
  logic [N*DATA_WIDTH-1:0] a_edge;
  logic [N*DATA_WIDTH-1:0] b_edge;
  logic                    clear_acc;
  logic                    enable;
  logic                    busy;
  logic                    done;

  modport master (
    output start, k_len, in_valid, a_vec, b_vec,
    input  in_ready, a_edge, b_edge, clear_acc, enable, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec,
    output in_ready, a_edge, b_edge, clear_acc, enable, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Skews K-step operand beats onto the west/north edges of an N x N
// output-stationary array and sequences clear/enable/done for one pass.
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int K_WIDTH    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  systolic_feeder_if.slave bus
);
  // The last beat needs 2N-1 cycles after its handshake to reach PE(N-1,N-1).
  localparam int FLUSH_LEN = 2 * N - 1;
  localparam int FLUSH_W   = $clog2(FLUSH_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [K_WIDTH-1:0]   k_len_reg, k_len_next;
  logic [K_WIDTH-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [FLUSH_W-1:0]   flush_cnt_reg, flush_cnt_next;
  logic                 in_ready_reg;
  logic                 enable_reg;
  logic                 clear_acc_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 take;
  logic [N*DATA_WIDTH-1:0] a_edge_w;
  logic [N*DATA_WIDTH-1:0] b_edge_w;

  assign take = bus.in_valid & in_ready_reg;

  always_comb begin
    state_next     = state_reg;
    k_len_next     = k_len_reg;
    beat_cnt_next  = beat_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          k_len_next    = bus.k_len;
          beat_cnt_next = '0;
          state_next    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_next = (k_len_reg == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        if (take) begin
          beat_cnt_next = beat_cnt_reg + K_WIDTH'(1);
          if (beat_cnt_reg + K_WIDTH'(1) == k_len_reg) begin
            flush_cnt_next = '0;
            state_next     = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_reg == FLUSH_W'(FLUSH_LEN - 1)) begin
          state_next = S_DONE;
        end else begin
          flush_cnt_next = flush_cnt_reg + FLUSH_W'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      k_len_reg     <= '0;
      beat_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      in_ready_reg  <= 1'b0;
      enable_reg    <= 1'b0;
      clear_acc_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      k_len_reg     <= k_len_next;
      beat_cnt_reg  <= beat_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      in_ready_reg  <= (state_next == S_FEED);
      enable_reg    <= (state_next == S_FEED) || (state_next == S_FLUSH);
      clear_acc_reg <= (state_next == S_CLEAR);
      busy_reg      <= (state_next != S_IDLE);
      done_reg      <= (state_next == S_DONE);
    end
  end

  // Lane gi of both edges is a (gi+1)-deep chain; non-handshake cycles inject zeros.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] a_stage_reg [0:gi];
      logic [DATA_WIDTH-1:0] b_stage_reg [0:gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s <= gi; s++) begin
            a_stage_reg[s] <= '0;
            b_stage_reg[s] <= '0;
          end
        end else begin
          a_stage_reg[0] <= take ? bus.a_vec[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
          b_stage_reg[0] <= take ? bus.b_vec[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
          for (int s = 1; s <= gi; s++) begin
            a_stage_reg[s] <= a_stage_reg[s-1];
            b_stage_reg[s] <= b_stage_reg[s-1];
          end
        end
      end

      assign a_edge_w[gi*DATA_WIDTH +: DATA_WIDTH] = a_stage_reg[gi];
      assign b_edge_w[gi*DATA_WIDTH +: DATA_WIDTH] = b_stage_reg[gi];
    end
  endgenerate

  assign bus.a_edge    = a_edge_w;
  assign bus.b_edge    = b_edge_w;
  assign bus.in_ready  = in_ready_reg;
  assign bus.enable    = enable_reg;
  assign bus.clear_acc = clear_acc_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench: feeder drives a behavioural 4x4 output-stationary PE grid;
// per-cycle control/edge expectations plus a result queue popped on done.
module tb_systolic_feeder;
  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int KW   = 16;
  localparam int KMAX = 8;

  localparam logic [4:0] M_READY = 5'b10000;
  localparam logic [4:0] M_EN    = 5'b01000;
  localparam logic [4:0] M_CLEAR = 5'b00100;
  localparam logic [4:0] M_BUSY  = 5'b00010;
  localparam logic [4:0] M_DONE  = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.DATA_WIDTH(DW), .N(N), .K_WIDTH(KW)) bus ();

  systolic_feeder #(.DATA_WIDTH(DW), .N(N), .K_WIDTH(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Expectations keyed by cycle number (cycle c ends at the c-th rising edge).
  logic [4:0]      exp_ctl [int];
  logic [N*DW-1:0] beat_a  [int];
  logic [N*DW-1:0] beat_b  [int];
  int              exp_q   [$];

  int am [N][KMAX];
  int bm [KMAX][N];

  // Behavioural PE grid state
  int                    acc  [N][N];
  logic signed [DW-1:0]  ar   [N][N];
  logic signed [DW-1:0]  br   [N][N];
  logic signed [DW-1:0]  a_at [N][N];
  logic signed [DW-1:0]  b_at [N][N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp, input int c);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
  endtask

  task automatic set_ctl(input int c, input logic [4:0] m);
    if (exp_ctl.exists(c)) exp_ctl[c] = exp_ctl[c] | m;
    else exp_ctl[c] = m;
  endtask

  // PE(i,j): a from the west, b from the north, acc += a*b while enabled.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_at[i][j] = (j == 0) ? $signed(bus.a_edge[i*DW +: DW]) : ar[i][j-1];
        b_at[i][j] = (i == 0) ? $signed(bus.b_edge[j*DW +: DW]) : br[i-1][j];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (bus.clear_acc) acc[i][j] <= 0;
        else if (bus.enable) acc[i][j] <= acc[i][j] + int'(a_at[i][j]) * int'(b_at[i][j]);
      end
    end
    ar <= a_at;
    br <= b_at;
  end

  // Monitor
  always @(negedge clk) begin
    int cur;
    int e;
    logic [4:0] got_ctl;
    logic [4:0] want_ctl;
    logic [N*DW-1:0] ea, eb, tmp;
    cur = cyc + 1;
    got_ctl  = {bus.in_ready, bus.enable, bus.clear_acc, bus.busy, bus.done};
    want_ctl = exp_ctl.exists(cur) ? exp_ctl[cur] : 5'b0;
    chk(got_ctl == want_ctl, "ctl{rdy,en,clr,busy,done}", longint'(got_ctl), longint'(want_ctl), cur);
    ea = '0;
    eb = '0;
    for (int i = 0; i < N; i++) begin
      if (beat_a.exists(cur - 1 - i)) begin
        tmp = beat_a[cur - 1 - i];
        ea[i*DW +: DW] = tmp[i*DW +: DW];
      end
      if (beat_b.exists(cur - 1 - i)) begin
        tmp = beat_b[cur - 1 - i];
        eb[i*DW +: DW] = tmp[i*DW +: DW];
      end
    end
    chk(bus.a_edge == ea, "a_edge", longint'(bus.a_edge), longint'(ea), cur);
    chk(bus.b_edge == eb, "b_edge", longint'(bus.b_edge), longint'(eb), cur);
    if (bus.done) begin
      $display("pass done at cycle %0d acc00=%0d acc33=%0d", cur, acc[0][0], acc[N-1][N-1]);
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "acc_unexpected_done", longint'(acc[i][j]), 0, cur);
          end else begin
            e = exp_q.pop_front();
            chk(acc[i][j] == e, $sformatf("acc(%0d,%0d)", i, j), longint'(acc[i][j]), longint'(e), cur);
          end
        end
      end
    end
  end

  // One pass; entered and left one ns after a rising edge.
  task automatic run_pass(input int k, input logic [31:0] vpat, input bit hold, input int abort_after);
    int s, c, n, p, last, done_c, x;
    int cexp [N][N];
    logic [N*DW-1:0] av, bv;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        cexp[i][j] = 0;
        for (int kk = 0; kk < k; kk++) cexp[i][j] += am[i][kk] * bm[kk][j];
      end
    end
    s = cyc + 1;
    bus.start    = 1'b1;
    bus.k_len    = KW'(k);
    bus.in_valid = 1'b0;
    set_ctl(s + 1, M_CLEAR | M_BUSY);
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    // Offered during CLEAR; must not be taken.
    bus.in_valid = 1'b1;
    bus.a_vec    = (N*DW)'($urandom);
    bus.b_vec    = (N*DW)'($urandom);
    @(posedge clk); #1;
    c = s + 2;
    n = 0;
    p = 0;
    while (n < k) begin
      if (n == abort_after) begin
        #1 rst_n = 1'b0;
        #1;
        chk({bus.in_ready, bus.enable, bus.clear_acc, bus.busy, bus.done} == 5'b0 &&
            bus.a_edge == '0 && bus.b_edge == '0, "async_reset_outputs",
            longint'({bus.in_ready, bus.enable, bus.clear_acc, bus.busy, bus.done, |bus.a_edge, |bus.b_edge}), 0, c);
        for (int y = c; y < c + 200; y++) exp_ctl.delete(y);
        beat_a.delete();
        beat_b.delete();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      set_ctl(c, M_READY | M_EN | M_BUSY);
      if (p >= 32 || vpat[p]) begin
        for (int i = 0; i < N; i++) begin
          x = am[i][n];
          av[i*DW +: DW] = x[DW-1:0];
          x = bm[n][i];
          bv[i*DW +: DW] = x[DW-1:0];
        end
        bus.in_valid = 1'b1;
        bus.a_vec    = av;
        bus.b_vec    = bv;
        beat_a[c]    = av;
        beat_b[c]    = bv;
        n++;
      end else begin
        bus.in_valid = 1'b0;
        bus.a_vec    = (N*DW)'($urandom);
        bus.b_vec    = (N*DW)'($urandom);
      end
      p++;
      @(posedge clk); #1;
      c++;
    end
    last = c - 1;
    if (k == 0) begin
      done_c = s + 2;
    end else begin
      done_c = last + 2 * N;
      for (int f = last + 1; f < done_c; f++) set_ctl(f, M_EN | M_BUSY);
    end
    set_ctl(done_c, M_BUSY | M_DONE);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_q.push_back(cexp[i][j]);
    // Back-pressure: valid held with junk while the feeder is not ready.
    bus.in_valid = 1'b1;
    bus.a_vec    = (N*DW)'($urandom);
    bus.b_vec    = (N*DW)'($urandom);
    while (cyc + 1 <= done_c) begin
      @(posedge clk); #1;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic fill_random(input bit extreme);
    int r;
    for (int i = 0; i < N; i++) begin
      for (int kk = 0; kk < KMAX; kk++) begin
        r = int'($urandom_range(0, 3));
        am[i][kk] = !extreme ? int'($urandom_range(0, 255)) - 128 :
                    (r == 0) ? 127 : (r == 1) ? -127 : (r == 2) ? -128 : int'($urandom_range(0, 255)) - 128;
        r = int'($urandom_range(0, 3));
        bm[kk][i] = !extreme ? int'($urandom_range(0, 255)) - 128 :
                    (r == 0) ? 127 : (r == 1) ? -127 : (r == 2) ? -128 : int'($urandom_range(0, 255)) - 128;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start    = 1'b0;
    bus.k_len    = '0;
    bus.in_valid = 1'b0;
    bus.a_vec    = '0;
    bus.b_vec    = '0;
    rst_n        = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      bus.start    = 1'($urandom);
      bus.in_valid = 1'($urandom);
      bus.a_vec    = (N*DW)'($urandom);
      bus.b_vec    = (N*DW)'($urandom);
      bus.k_len    = KW'($urandom);
    end
    chk({bus.in_ready, bus.enable, bus.clear_acc, bus.busy, bus.done} == 5'b0 &&
        bus.a_edge == '0 && bus.b_edge == '0, "reset_outputs",
        longint'({bus.in_ready, bus.enable, bus.clear_acc, bus.busy, bus.done}), 0, cyc + 1);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin
      @(posedge clk); #1;
    end

    // Single beat: A column {1,2,3,4}, B row {5,6,7,8}
    for (int i = 0; i < N; i++) begin
      am[i][0] = i + 1;
      bm[0][i] = i + 5;
    end
    run_pass(1, '1, 1'b0, -1);

    // Identity A times random signed B
    fill_random(1'b0);
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < N; kk++) am[i][kk] = (i == kk) ? 1 : 0;
    run_pass(4, '1, 1'b0, -1);

    // Extremes +-127 / -128
    fill_random(1'b1);
    run_pass(4, '1, 1'b0, -1);

    // Same operands, back-to-back then with bubbles 1,0,1,0,1
    fill_random(1'b0);
    run_pass(3, '1, 1'b0, -1);
    run_pass(3, 32'h0000_0015, 1'b0, -1);

    // Empty pass
    run_pass(0, '1, 1'b0, -1);

    // Reset mid-FEED, then a fresh pass
    fill_random(1'b0);
    run_pass(4, '1, 1'b0, 2);
    run_pass(4, '1, 1'b0, -1);

    // start held through an entire pass
    fill_random(1'b1);
    run_pass(2, '1, 1'b1, -1);
    repeat (4) begin
      @(posedge clk); #1;
    end

    // Random passes with random bubble patterns
    for (int r = 0; r < 6; r++) begin
      fill_random(r[0]);
      run_pass(int'($urandom_range(1, KMAX)), $urandom, 1'b0, -1);
      repeat (int'($urandom_range(0, 2))) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) begin
      @(posedge clk); #1;
    end
    chk(exp_q.size() == 0, "results_outstanding", longint'(exp_q.size()), 0, cyc + 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand skew and sequencing front-end for the output-stationary systolic array. It accepts one K-step operand beat per handshake: column k of A and row k of B. It drives the array's west (a) and north (b) edges with the diagonal skew the PE grid requires, and generates the array-wide `clear_acc` and `enable` controls for one matrix-multiply pass. It signals `done` once every PE accumulator holds its final dot product.

## Interface
- `DATA_WIDTH`, 8, operand width (signed, passed through unmodified)
- `N`, 4, array dimension (N rows × N columns of PEs)
- `K_WIDTH`, 16, width of the K-length field

- `clk`  in  1  clock
- `rst_n`  in  1  reset (asynchronous, active-low)
- `start`  in  1  begin a pass; sampled only in IDLE
- `k_len`  in  K_WIDTH  number of operand beats in the pass; latched on accepted `start`
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  feeder accepts a beat (FEED state only)
- `a_vec`  in  N*DATA_WIDTH  A[:,k]; row i at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `b_vec`  in  N*DATA_WIDTH  B[k,:]; column j at `[j*DATA_WIDTH +: DATA_WIDTH]`
- `a_edge`  out  N*DATA_WIDTH  to `a_in` of PE(i,0), row i packed as `a_vec`
- `b_edge`  out  N*DATA_WIDTH  to `b_in` of PE(0,j), column j packed as `b_vec`
- `clear_acc`  out  1  broadcast to all PEs
- `enable`  out  1  broadcast to all PEs
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse; accumulators are final

## Operation
- **FSM:** IDLE → CLEAR → FEED → FLUSH → DONE → IDLE.
- **IDLE:** `start` = 1 latches `k_len` and moves to CLEAR. `start` is ignored in every other state.
- **CLEAR:** lasts 1 cycle, with `clear_acc` = 1 and `enable` = 0.
  - `k_len` = 0 → next state is DONE.
  - Otherwise → next state is FEED.
- **FEED:**
  - `in_ready` = 1 and `enable` = 1.
  - Each handshake (`in_valid` & `in_ready`) pushes `a_vec` and `b_vec` into the skew lines and increments the beat counter.
  - A cycle without a handshake pushes zeros into every lane (a bubble). Zero a-values only ever meet zero b-values in the array, so bubbles are result-neutral.
  - After the `k_len`-th handshake → FLUSH.
- **FLUSH:**
  - Lasts exactly 2N−1 cycles with `enable` = 1 and `in_ready` = 0.
  - Zeros are pushed into all lanes.
- **DONE:** lasts 1 cycle with `done` = 1, `enable` = 0, and `busy` = 1; next state is IDLE.
- **Skew lines:**
  - Row i of `a_edge` is an (i+1)-stage register chain.
  - Column j of `b_edge` is a (j+1)-stage register chain.
  - There is no arithmetic on the data path; values pass bit-exact, including −2^(DATA_WIDTH−1).
- **Control outputs:** `a_edge`, `b_edge`, `clear_acc`, `enable`, `in_ready`, `busy`, and `done` are all registered, or decoded directly from registered state.

## Timing
- **Reset values:** all outputs are 0, all skew stages are 0, and the state is IDLE.
- **Reset mid-pass:** asserting `rst_n` low at any point clears everything asynchronously. No partial pass resumes.
- **Start to CLEAR:** if `start` is sampled high in IDLE on the cycle-s edge, CLEAR occupies cycle s+1 and FEED begins at s+2.
- **Edge latency:** a beat accepted at edge t appears on `a_edge` row i only during cycle t+1+i, and on `b_edge` column j only during cycle t+1+j. In every other cycle those lanes carry 0.
- **Array arrival:** the last beat reaches PE(N−1,N−1) at cycle L+1+2(N−1), where L is the last handshake. FLUSH covers L+1 through L+2N−1, so `enable` is high there.
- **Result availability:** DONE is cycle L+2N. All accumulators are final from the DONE cycle onward and hold until the next `clear_acc`.
- **Back-to-back pass length:** with no bubbles, `start` to `done` is 1 + 1 + k_len + (2N−1) + 1 cycles.
- **`k_len` = 0:** `done` occurs 2 cycles after `start` is sampled, and `enable` never asserts.
- **`start` with `done`:** `start` asserted in the DONE cycle is ignored. A new pass needs `start` in IDLE.
- **Back-pressure:** `in_valid` may hold high while `in_ready` is low. No beat is taken outside FEED, and none beyond `k_len`.

## Test plan
- **Reset:** assert `rst_n` = 0 with random inputs. All outputs must read 0 and `in_ready` = 0. After release, 5 idle cycles must show no output activity.
- **Single beat (N=4, k_len=1):** `start` at s, `a_vec` rows {1,2,3,4}, `b_vec` columns {5,6,7,8}, beat accepted at s+2.
  - `a_edge` row i = i+1 only at s+3+i.
  - `b_edge` column j = j+5 only at s+3+j.
  - `clear_acc` is high only at s+1.
  - `done` is high only at s+10.
- **Full matmul:** feeder drives a behavioral 4×4 PE grid. Run k_len=4 with A = identity and random signed B, then run A and B containing ±127 and −128. Every acc(i,j) must equal Σ A[i][k]·B[k][j] at `done`.
- **Bubbles:** k_len=3 with `in_valid` toggling 1,0,1,0,1. Accumulators must match the back-to-back run, and `done` must be 2 cycles later than back-to-back.
- **k_len=0:** `clear_acc` pulses, `done` fires 2 cycles after `start`, `enable` stays 0, and accumulators read 0.
- **Reset and ignored start:**
  - Pulse `rst_n` low mid-FEED: all outputs go to 0 immediately (asynchronous), and a fresh pass afterwards gives correct results.
  - Hold `start` high through an entire pass: exactly one pass occurs, and the next pass starts only from IDLE.
